md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the five-stage MIPS pipeline.
- Consumes the decoded md-class ops (mult, multu, div, divu, mthi, mtlo) and produces the HI/LO values read by mfhi/mflo.
- Models multi-cycle latency with a busy counter.
- The hazard unit stalls any md-class instruction in D while start or busy is high.

Parameters:
- MULT_CYCLES, 5, cycles busy is held after a mult/multu start (>=1).
- DIV_CYCLES, 10, cycles busy is held after a div/divu start (>=1).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  E-stage instruction is a valid md op this cycle
- md_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 8-11 see Optional Feature; others = no-op
- a  input  32  rs operand (forwarded)
- b  input  32  rt operand (forwarded)
- busy  output  1  computation in flight
- hi  output  32  architectural HI register
- lo  output  32  architectural LO register

Behaviour:
- Reset (asynchronous, any time, including mid-operation): hi=0, lo=0, busy=0, counter=0, pending result discarded.
- Accept rule: an op is accepted at a rising edge when start=1 and busy=0. start=1 with busy=1 is ignored; simulation builds flag it with $display.
- mthi / mtlo, when accepted: hi<=a (or lo<=a) at that edge. busy stays 0. No latency.
- mult/multu/div/divu, when accepted:
  - Compute the 64-bit result from a and b at that edge into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES; busy<=1.
- While busy, each edge decrements counter. On the edge where counter==1: hi<=pending_hi, lo<=pending_lo, busy<=0, counter<=0.
- busy is therefore high for exactly N cycles following the start cycle. hi/lo show new values in the cycle busy falls.
- hi/lo hold their old values throughout busy.
- mult: signed 32x32 -> 64; {hi,lo} = product.
- multu: unsigned 32x32 -> 64; {hi,lo} = product.
- div: signed; lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- divu: unsigned quotient/remainder.
- Divide by zero (div, divu): lo=32'hFFFFFFFF, hi=a.
- Signed overflow (div, a=32'h80000000, b=32'hFFFFFFFF): lo=32'h80000000, hi=0.
- md_op 0, 7, or other unused codes with start=1: no state change.
- A start in the same cycle busy falls is still rejected (busy is sampled before the edge). It is accepted the following cycle.
- States: IDLE (busy=0) -> BUSY on accepted mult/div. BUSY -> IDLE when counter==1. No other transitions except reset -> IDLE.

Optional Feature:
- Macro MD_MADD_EN.
- Defined: md_op 8 madd, 9 maddu, 10 msub, 11 msubu are accepted like mult.
  - Uses MULT_CYCLES.
  - pending = {hi,lo} ± product (signed/unsigned per op), modulo 2^64.
  - {hi,lo} is sampled at the accept edge.
- Not defined: codes 8-11 are no-ops (no busy, no state change).

Test Plan:
- Reset mid-mult: start mult a=3,b=4; assert reset at cycle 2 -> busy=0, hi=0, lo=0 immediately; no later writeback.
- Signed mult: a=32'hFFFFFFFE (-2), b=3 -> busy high 5 cycles; then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA. multu with the same operands -> hi=32'h00000002, lo=32'hFFFFFFFA.
- Signed div: a=-7, b=2 -> busy high 10 cycles; then lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). divu a=7,b=2 -> lo=3, hi=1.
- Boundary div: a=5,b=0 -> lo=32'hFFFFFFFF, hi=5. a=32'h80000000, b=-1 -> lo=32'h80000000, hi=0.
- mthi/mtlo and busy rejection:
  - mthi a=32'h12345678 -> hi updated the next cycle, busy stays 0.
  - start mtlo while a div is busy -> ignored; lo takes the div result.
  - start asserted in the cycle busy falls -> rejected.
- MD_MADD_EN: {hi,lo}={0,5}; madd a=2,b=3 -> after 5 cycles hi=0, lo=11. msubu a=1,b=12 from {0,11} -> hi=lo=32'hFFFFFFFF. Without the macro, md_op=8 -> no busy, hi/lo unchanged.

Source files
------------

// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: produces HI/LO for mult/div/mthi/mtlo with a
// modelled multi-cycle latency. Define MD_MADD_EN to add madd/maddu/msub/msubu.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
  localparam logic [3:0] OP_MSUBU = 4'd11;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   count, count_nx;
  logic [63:0]        pend, pend_nx;
  logic [31:0]        hi_nx, lo_nx;
  logic               busy_nx;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        quo_s, rem_s, quo_u, rem_u;

  assign prod_s = 64'($signed(a)) * 64'($signed(b));
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divide results with the zero-divisor and signed-overflow cases pinned down.
  always_comb begin
    if (b == 32'd0) begin
      quo_s = 32'hFFFF_FFFF;
      rem_s = a;
      quo_u = 32'hFFFF_FFFF;
      rem_u = a;
    end else begin
      quo_u = a / b;
      rem_u = a % b;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        quo_s = 32'h8000_0000;
        rem_s = 32'd0;
      end else begin
        quo_s = 32'($signed(a) / $signed(b));
        rem_s = 32'($signed(a) % $signed(b));
      end
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    pend_nx  = pend;
    hi_nx    = hi;
    lo_nx    = lo;
    busy_nx  = busy;
    case (state)
      IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT:  pend_nx = $unsigned(prod_s);
            OP_MULTU: pend_nx = prod_u;
            OP_DIV:   pend_nx = {rem_s, quo_s};
            OP_DIVU:  pend_nx = {rem_u, quo_u};
            OP_MTHI:  hi_nx   = a;
            OP_MTLO:  lo_nx   = a;
`ifdef MD_MADD_EN
            OP_MADD:  pend_nx = {hi, lo} + $unsigned(prod_s);
            OP_MADDU: pend_nx = {hi, lo} + prod_u;
            OP_MSUB:  pend_nx = {hi, lo} - $unsigned(prod_s);
            OP_MSUBU: pend_nx = {hi, lo} - prod_u;
`endif
            default: ;
          endcase
          case (md_op)
            OP_MULT, OP_MULTU
`ifdef MD_MADD_EN
            , OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
`endif
            : begin
              count_nx = CNT_W'(MULT_CYCLES);
              busy_nx  = 1'b1;
              state_nx = BUSY;
            end
            OP_DIV, OP_DIVU: begin
              count_nx = CNT_W'(DIV_CYCLES);
              busy_nx  = 1'b1;
              state_nx = BUSY;
            end
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (count == CNT_W'(1)) begin
          hi_nx    = pend[63:32];
          lo_nx    = pend[31:0];
          busy_nx  = 1'b0;
          count_nx = '0;
          state_nx = IDLE;
        end else begin
          count_nx = count - CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      pend  <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      pend  <= pend_nx;
      hi    <= hi_nx;
      lo    <= lo_nx;
      busy  <= busy_nx;
    end
  end

`ifndef SYNTHESIS
  // A start that arrives while busy is dropped; make that visible in simulation.
  always_ff @(posedge clk) begin
    if (!reset && start && busy)
      $info("md_unit: start ignored while busy (md_op=%0d)", md_op);
  end
`endif

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit with hand-computed HI/LO and latency expectations.
module tb_md_unit;
  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] mhi = 32'd0;
  logic [31:0] mlo = 32'd0;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Issue one op, count busy cycles, then check latency and final HI/LO.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input int cyc,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    @(negedge clk);
    start = 1'b1; md_op = op; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; md_op = 4'd0;
    n = 0;
    while (busy && n < 40) begin
      if (n == 0) begin
        check({tag, "_hold_hi"}, hi, mhi);
        check({tag, "_hold_lo"}, lo, mlo);
      end
      n++;
      @(negedge clk);
    end
    check({tag, "_cycles"}, 32'(n), 32'(cyc));
    check({tag, "_hi"}, hi, ehi);
    check({tag, "_lo"}, lo, elo);
    mhi = ehi;
    mlo = elo;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b0;

    // Reset asserted mid-mult clears everything and cancels the writeback.
    @(negedge clk);
    start = 1'b1; md_op = 4'd1; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0; md_op = 4'd0;
    check("midrst_busy_pre", 32'(busy), 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_late_busy", 32'(busy), 32'd0);
    check("midrst_late_hi", hi, 32'd0);
    check("midrst_late_lo", lo, 32'd0);

    run_op("mult",  4'd1, 32'hFFFF_FFFE, 32'd3, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, MC, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("mult_big", 4'd1, 32'h8000_0000, 32'h8000_0000, MC, 32'h4000_0000, 32'h0000_0000);
    run_op("div",   4'd3, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_pn", 4'd3, 32'd7, 32'hFFFF_FFFE, DC, 32'd1, 32'hFFFF_FFFD);
    run_op("divu",  4'd4, 32'd7, 32'd2, DC, 32'd1, 32'd3);
    run_op("divu_big", 4'd4, 32'hFFFF_FFF9, 32'd2, DC, 32'd1, 32'h7FFF_FFFC);
    run_op("div0",  4'd3, 32'd5, 32'd0, DC, 32'd5, 32'hFFFF_FFFF);
    run_op("divu0", 4'd4, 32'd5, 32'd0, DC, 32'd5, 32'hFFFF_FFFF);
    run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'd0, 32'h8000_0000);
    run_op("mthi",  4'd5, 32'h1234_5678, 32'd0, 0, 32'h1234_5678, 32'h8000_0000);
    run_op("mtlo",  4'd6, 32'hA5A5_0F0F, 32'd0, 0, 32'h1234_5678, 32'hA5A5_0F0F);
    run_op("nop7",  4'd7, 32'hDEAD_BEEF, 32'd1, 0, 32'h1234_5678, 32'hA5A5_0F0F);

    // mtlo issued while a div is in flight is dropped.
    @(negedge clk);
    start = 1'b1; md_op = 4'd3; a = 32'd9; b = 32'd4;
    @(negedge clk);
    start = 1'b0; md_op = 4'd0;
    repeat (2) @(negedge clk);
    start = 1'b1; md_op = 4'd6; a = 32'hDEAD_0001;
    @(negedge clk);
    start = 1'b0; md_op = 4'd0;
    check("busyrej_lo_mid", lo, 32'hA5A5_0F0F);
    repeat (DC) @(negedge clk);
    check("busyrej_busy", 32'(busy), 32'd0);
    check("busyrej_hi", hi, 32'd1);
    check("busyrej_lo", lo, 32'd2);

    // Start in the last busy cycle is rejected, then accepted a cycle later.
    @(negedge clk);
    start = 1'b1; md_op = 4'd1; a = 32'd2; b = 32'd3;
    @(negedge clk);
    start = 1'b0; md_op = 4'd0;
    repeat (MC - 1) @(negedge clk);
    check("fall_busy_last", 32'(busy), 32'd1);
    start = 1'b1; md_op = 4'd5; a = 32'h0000_CAFE;
    @(negedge clk);
    check("fall_busy", 32'(busy), 32'd0);
    check("fall_hi_rej", hi, 32'd0);
    check("fall_lo", lo, 32'd6);
    @(negedge clk);
    start = 1'b0; md_op = 4'd0;
    check("fall_hi_acc", hi, 32'h0000_CAFE);
    check("fall_busy_acc", 32'(busy), 32'd0);
    mhi = 32'h0000_CAFE;
    mlo = 32'd6;

    run_op("set_hi", 4'd5, 32'd0, 32'd0, 0, 32'd0, 32'd6);
    run_op("set_lo", 4'd6, 32'd5, 32'd0, 0, 32'd0, 32'd5);
`ifdef MD_MADD_EN
    run_op("madd",  4'd8,  32'd2, 32'd3,  MC, 32'd0, 32'd11);
    run_op("msubu", 4'd11, 32'd1, 32'd12, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("msub",  4'd10, 32'hFFFF_FFFF, 32'd1, MC, 32'd0, 32'd0);
    run_op("maddu", 4'd9,  32'hFFFF_FFFF, 32'd2, MC, 32'd1, 32'hFFFF_FFFE);
`else
    run_op("madd_off",  4'd8,  32'd2, 32'd3,  0, 32'd0, 32'd5);
    run_op("msubu_off", 4'd11, 32'd1, 32'd12, 0, 32'd0, 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
